nanojeff_mem: RTL and testbench
===============================

# nanojeff_mem

Parametrised unified instruction/data memory for the NanoJeff core, replacing the bench-only 256×8 array with a synthesizable block. It has:
- an asynchronous instruction read port and an asynchronous data read port;
- a synchronous data write port;
- a boot loader that streams the program in over a valid/ready interface while it holds the core in reset;
- one memory-mapped output register, used for the board LED.

It sits between the NanoJeff core and the board/host programming link.

## Interface
Parameters:
- DATA_W, 8, word width of memory, loader data and IO register.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- IO_ADDR, 2**ADDR_W-1, data address that is mapped to io_out instead of RAM.
- BOOT_LOAD, 1, 1 = enter LOAD after reset; 0 = enter RUN directly (RAM keeps its previous contents).

Ports:
- clk  in  1  single clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- iaddr  in  ADDR_W  core instruction address.
- inst  out  DATA_W  instruction word, mem[iaddr], combinational.
- daddr  in  ADDR_W  core data address.
- data  out  DATA_W  read data: io_out if daddr==IO_ADDR, else mem[daddr]; combinational.
- wdata  in  DATA_W  core write data.
- wen  in  1  core write enable.
- ld_valid  in  1  loader beat valid.
- ld_ready  out  1  loader beat ready.
- ld_data  in  DATA_W  loader word.
- ld_last  in  1  final beat of the image.
- cpu_reset  out  1  reset to the NanoJeff core.
- load_done  out  1  high in RUN.
- io_out  out  DATA_W  memory-mapped output register.

## Operation
- The FSM has two states, LOAD and RUN, plus a load pointer ptr[ADDR_W-1:0].
- **Reset:** applies when reset=1 at posedge.
  - state ← (BOOT_LOAD ? LOAD : RUN), ptr ← 0, io_out ← 0.
  - RAM contents are not cleared.
- **LOAD:**
  - ld_ready=1, cpu_reset=1, load_done=0.
  - A beat is accepted when ld_valid&&ld_ready: mem[ptr] ← ld_data, ptr ← ptr+1.
  - Accepting a beat with ld_last=1, or accepting the beat at ptr==DEPTH-1, moves the FSM to RUN.
  - ptr never wraps into a second pass.
- **RUN:**
  - ld_ready=0, cpu_reset=0, load_done=1.
  - A core write with wen=1 and daddr==IO_ADDR updates io_out ← wdata; RAM is untouched.
  - Any other core write with wen=1 writes mem[daddr] ← wdata.
- Core writes (wen) are ignored in LOAD.
- Loader signals are ignored in RUN.
- Reads are always live on both ports, including during LOAD, so the bench can inspect memory.
- Simultaneous iaddr==daddr write: inst shows the old word until the posedge, then the new word.
- A reset in the middle of a load aborts it. The loader must restart the image from word 0; words already written stay in RAM.

## Timing
- Outputs while reset=1: ld_ready=0, cpu_reset=1, load_done=0.
- After the reset posedge, all outputs take the values for the reset state. With BOOT_LOAD=1: ld_ready=1, cpu_reset=1, load_done=0, io_out=0.
- inst/data: zero-latency combinational reads, matching the core's single-cycle fetch/load.
- Writes (core, loader, io_out) become visible on reads immediately after the posedge that performs them.
- The LOAD→RUN transition happens at the posedge that accepts the last beat.
  - cpu_reset falls and load_done rises in the following cycle, so the core's first fetch sees the complete image.
  - ld_ready drops at that same posedge; no further beat can be accepted.
- Loader throughput: one word per cycle with ld_valid held high. A full DEPTH-word image takes DEPTH cycles.

## Structure
- Shared package nanojeff_pkg holds:
  - the state enum {LOAD, RUN};
  - default constants NJ_DATA_W=8 and NJ_ADDR_W=8, which NanoJeff also uses.
- Sub-module nanojeff_ram(DATA_W, ADDR_W) holds the storage array: two async read ports and one sync write port (we, waddr, wdata).
- The top level muxes the write source (loader in LOAD, core in RUN) onto that single write port and contains the FSM and the IO register.

## Test plan
- **Reset/boot:** BOOT_LOAD=1. Hold reset 2 cycles, then release. Required: ld_ready=1, cpu_reset=1, io_out=0. Also required: cpu_reset=1 and ld_ready=0 while reset is high.
- **Load image:**
  - Stream 14 words (0x50,0x55,0x5A,0x5F,0xAF,0xBF,0x6C,0x50,0x9C,0xA1,0x64,0x9C,0x61,0xF1) with ld_last on 0xF1.
  - Required: mem[0..13] holds these words; load_done=1 and cpu_reset=0 one cycle after the last accept.
  - Back-pressure: drop ld_valid every other cycle; the result must be identical.
- **Full-depth wrap:** stream 256 words with no ld_last. Required: RUN is entered after the accept at ptr=255, and mem[0] is not overwritten.
- **Core access in RUN:**
  - wen=1, daddr=0x20, wdata=0xA5 → data=0xA5 on the next cycle.
  - wen=1, daddr=0xFF, wdata=0x01 → io_out=0x01 and data at 0xFF reads 0x01, with RAM[0xFF] unchanged.
- **Ignored traffic:**
  - wen=1 during LOAD → no RAM change.
  - ld_valid=1 in RUN → ld_ready=0 and no RAM change.
- **Reset mid-load:** accept 5 beats, then assert reset. Required: ptr=0 and state LOAD; mem[0..4] keeps the loaded words; reloading 3 words overwrites only mem[0..2].

Source files
------------

// File: rtl/nanojeff_pkg.sv
// nanojeff_pkg: definitions shared by the NanoJeff core and its memory.
//   nj_state_e : boot loader state (LOAD streams the image in, RUN lets the core own the memory)
//   NJ_DATA_W  : default word width
//   NJ_ADDR_W  : default address width
package nanojeff_pkg;

    localparam int NJ_DATA_W = 8;
    localparam int NJ_ADDR_W = 8;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } nj_state_e;

endpackage : nanojeff_pkg

// File: rtl/nanojeff_ram.sv
// nanojeff_ram: storage array with two asynchronous read ports and one
// synchronous write port. The array has no reset, so its contents survive
// a reset of the surrounding logic.
//   clk      in   write clock
//   we       in   write enable
//   waddr    in   write address
//   wdata    in   write data
//   raddr_a  in   read port A address
//   rdata_a  out  read port A data, combinational
//   raddr_b  in   read port B address
//   rdata_b  out  read port B data, combinational
module nanojeff_ram
    import nanojeff_pkg::*;
#(
    parameter int DATA_W = NJ_DATA_W,
    parameter int ADDR_W = NJ_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Reads see the old word until the posedge that writes it.
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule : nanojeff_ram

// File: rtl/nanojeff_mem.sv
// nanojeff_mem: unified instruction/data memory for the NanoJeff core with a
// boot loader and one memory-mapped output register.
//   clk        in   single clock
//   reset      in   synchronous, active-high
//   iaddr      in   instruction address
//   inst       out  mem[iaddr], combinational
//   daddr      in   data address
//   data       out  io_out when daddr==IO_ADDR, else mem[daddr], combinational
//   wdata      in   core write data
//   wen        in   core write enable (honoured in RUN only)
//   ld_valid   in   loader beat valid
//   ld_ready   out  loader beat ready (LOAD only)
//   ld_data    in   loader word
//   ld_last    in   final beat of the image
//   cpu_reset  out  holds the core in reset while loading or under reset
//   load_done  out  high in RUN
//   io_out     out  memory-mapped output register (board LED)
module nanojeff_mem
    import nanojeff_pkg::*;
#(
    parameter int                DATA_W    = NJ_DATA_W,
    parameter int                ADDR_W    = NJ_ADDR_W,
    parameter logic [ADDR_W-1:0] IO_ADDR   = {ADDR_W{1'b1}},
    parameter bit                BOOT_LOAD = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] inst,
    input  logic [ADDR_W-1:0] daddr,
    output logic [DATA_W-1:0] data,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wen,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              cpu_reset,
    output logic              load_done,
    output logic [DATA_W-1:0] io_out
);

    localparam nj_state_e RESET_STATE = BOOT_LOAD ? LOAD : RUN;

    nj_state_e         state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] io_out_q, io_out_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_dout;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        io_out_d  = io_out_q;
        ram_we    = 1'b0;
        ram_waddr = daddr;
        ram_wdata = wdata;
        // Nothing writes while reset is asserted; the flops take their
        // reset values in the register process.
        if (!reset) begin
            case (state_q)
                LOAD: begin
                    if (ld_valid) begin
                        ram_we    = 1'b1;
                        ram_waddr = ptr_q;
                        ram_wdata = ld_data;
                        // The pointer holds at the top word instead of
                        // wrapping, since the image is complete there.
                        if (ld_last || (&ptr_q)) begin
                            state_d = RUN;
                        end
                        if (!(&ptr_q)) begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (wen) begin
                        if (daddr == IO_ADDR) begin
                            io_out_d = wdata;
                        end else begin
                            ram_we = 1'b1;
                        end
                    end
                end
                default: state_d = RESET_STATE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RESET_STATE;
            ptr_q    <= '0;
            io_out_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            io_out_q <= io_out_d;
        end
    end

    nanojeff_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .raddr_a (iaddr),
        .rdata_a (inst),
        .raddr_b (daddr),
        .rdata_b (ram_dout)
    );

    // Reset overrides the state-derived controls so the core is held and
    // no beat is handshaken while reset is high.
    assign ld_ready  = !reset && (state_q == LOAD);
    assign cpu_reset =  reset || (state_q == LOAD);
    assign load_done = !reset && (state_q == RUN);
    assign io_out    = io_out_q;
    assign data      = (daddr == IO_ADDR) ? io_out_q : ram_dout;

endmodule : nanojeff_mem

// File: tb/tb_nanojeff_mem.sv
module tb_nanojeff_mem;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int IOA   = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] iaddr = '0;
    logic [DW-1:0] inst;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] data;
    logic [DW-1:0] wdata = '0;
    logic          wen = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          cpu_reset;
    logic          load_done;
    logic [DW-1:0] io_out;

    always #5 clk = ~clk;

    nanojeff_mem #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .IO_ADDR   (8'hFF),
        .BOOT_LOAD (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .iaddr     (iaddr),
        .inst      (inst),
        .daddr     (daddr),
        .data      (data),
        .wdata     (wdata),
        .wen       (wen),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .io_out    (io_out)
    );

    // Behavioural model: memory image, which words are known, loader status.
    int unsigned   m_mem   [DEPTH];
    bit            m_known [DEPTH];
    bit            m_loading = 1'b1;
    int            m_ptr = 0;
    int unsigned   m_io = 0;

    typedef struct {
        string       name;
        int unsigned inst;
        bit          inst_k;
        int unsigned data;
        bit          data_k;
        bit          rdy;
        bit          crst;
        bit          done;
        int unsigned io;
    } exp_t;

    exp_t sbq[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input string field,
                       input int unsigned act, input int unsigned expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%0h, required 0x%0h", name, field, act, expv);
        end
    endtask

    // Monitor: mid low phase, compares the outputs the DUT presents against
    // the oldest expectation issued by the stimulus.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.inst_k) chk(e.name, "inst", int'(inst), e.inst);
                if (e.data_k) chk(e.name, "data", int'(data), e.data);
                chk(e.name, "ld_ready",  int'(ld_ready),  int'(e.rdy));
                chk(e.name, "cpu_reset", int'(cpu_reset), int'(e.crst));
                chk(e.name, "load_done", int'(load_done), int'(e.done));
                chk(e.name, "io_out",    int'(io_out),    e.io);
            end
        end
    end

    // One cycle of stimulus: drive inputs, push the expected outputs for
    // this cycle, then advance the model by the effect of the next posedge.
    task automatic cyc(input string name, input bit rst,
                       input bit lv, input int unsigned ld, input bit ll,
                       input bit we, input int unsigned da, input int unsigned wd,
                       input int unsigned ia);
        exp_t e;
        @(negedge clk);
        reset    = rst;
        ld_valid = lv;
        ld_data  = DW'(ld);
        ld_last  = ll;
        wen      = we;
        daddr    = AW'(da);
        wdata    = DW'(wd);
        iaddr    = AW'(ia);

        e.name   = name;
        e.inst   = m_mem[ia];
        e.inst_k = m_known[ia];
        e.data   = (da == IOA) ? m_io : m_mem[da];
        e.data_k = (da == IOA) ? 1'b1 : m_known[da];
        e.rdy    = !rst && m_loading;
        e.crst   = rst || m_loading;
        e.done   = !rst && !m_loading;
        e.io     = m_io;
        sbq.push_back(e);

        if (rst) begin
            m_loading = 1'b1;
            m_ptr     = 0;
            m_io      = 0;
        end else if (m_loading) begin
            if (lv) begin
                m_mem[m_ptr]   = ld & 8'hFF;
                m_known[m_ptr] = 1'b1;
                if (ll || m_ptr == DEPTH - 1) m_loading = 1'b0;
                m_ptr++;
            end
        end else if (we) begin
            if (da == IOA) m_io = wd & 8'hFF;
            else begin
                m_mem[da]   = wd & 8'hFF;
                m_known[da] = 1'b1;
            end
        end
    endtask

    task automatic idle(input string name, input int da, input int ia);
        cyc(name, 1'b0, 1'b0, 0, 1'b0, 1'b0, da, 0, ia);
    endtask

    int unsigned img [14] = '{8'h50, 8'h55, 8'h5A, 8'h5F, 8'hAF, 8'hBF, 8'h6C,
                              8'h50, 8'h9C, 8'hA1, 8'h64, 8'h9C, 8'h61, 8'hF1};

    initial begin
        int guard;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = 0;
            m_known[i] = 1'b0;
        end

        // Reset held for two cycles, then released into LOAD.
        cyc("reset0", 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 0, 8'h22, 0);
        cyc("reset1", 1'b1, 1'b1, 8'h33, 1'b1, 1'b1, 1, 8'h44, 1);
        idle("boot", 0, 0);

        // 14-word image, one per cycle, stray core writes during LOAD.
        for (int i = 0; i < 14; i++)
            cyc("load", 1'b0, 1'b1, img[i], i == 13, 1'b1,
                $urandom_range(0, 254), $urandom_range(0, 255), (i > 0) ? i - 1 : 0);
        for (int i = 0; i < 14; i++) idle("img_rd", i, 13 - i);

        // Same image under back-pressure; idle beats carry junk and ld_last.
        cyc("reset_bp", 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            cyc("bp_load", 1'b0, 1'b1, img[i], i == 13, 1'b0, i, 0, i);
            if (i != 13)
                cyc("bp_gap", 1'b0, 1'b0, $urandom_range(0, 255), $urandom_range(0, 1),
                    1'b1, $urandom_range(20, 254), $urandom_range(0, 255), i);
        end
        for (int i = 0; i < 14; i++) idle("bp_rd", i, i);

        // RUN: loader traffic is ignored.
        for (int i = 0; i < 6; i++)
            cyc("run_ld_ign", 1'b0, 1'b1, $urandom_range(0, 255), i[0], 1'b0, i, 0, 13 - i);

        // Core data write and IO register write.
        cyc("wr20", 1'b0, 1'b0, 0, 1'b0, 1'b1, 8'h20, 8'hA5, 8'h20);
        idle("rd20", 8'h20, 8'h20);
        cyc("wrio", 1'b0, 1'b0, 0, 1'b0, 1'b1, 8'hFF, 8'h01, 8'hFF);
        idle("rdio", 8'hFF, 8'hFF);

        // Full-depth image with no ld_last; extra beats after the top word.
        cyc("reset_full", 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < DEPTH + 3; i++)
            cyc("full_load", 1'b0, 1'b1, $urandom_range(0, 255), 1'b0, 1'b0,
                $urandom_range(0, 254), 0, 0);
        for (int i = 0; i < 4; i++) idle("full_rd", i, 255 - i);

        // Reset mid-load: five beats, abort, three beats of a new image.
        cyc("reset_mid", 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc("mid_load5", 1'b0, 1'b1, $urandom_range(0, 255), 1'b0, 1'b0, i, 0, i);
        cyc("mid_abort", 1'b1, 1'b1, 8'hEE, 1'b0, 1'b0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc("mid_load3", 1'b0, 1'b1, $urandom_range(0, 255), i == 2, 1'b0, i, 0, i);
        for (int i = 0; i < 8; i++) idle("mid_rd", i, 7 - i);

        // Random core traffic in RUN, including the IO address.
        for (int i = 0; i < 200; i++)
            cyc("run_rand", 1'b0, $urandom_range(0, 1), $urandom_range(0, 255),
                $urandom_range(0, 1), $urandom_range(0, 1),
                ($urandom_range(0, 7) == 0) ? IOA : $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255));

        guard = 0;
        while (sbq.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #4;
        if (sbq.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_nanojeff_mem
